// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stages: default sizes and
// the decoder FSM state encoding.
package sc_pkg;

    localparam int unsigned SC_WIDTH  = 8;
    localparam int unsigned SC_WINDOW = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_state_t;

endpackage

// File: rtl/sc_compare.sv
// Unsigned less-than comparator; turns a random word and a probability
// operand into one stochastic bit.
module sc_compare #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt
);

    assign lt = (a < b);

endmodule

// File: rtl/sc_stream_decoder.sv
// Converts a binary probability into a stochastic bit stream over one LFSR
// period and reports the number of ones seen in the completed window.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int unsigned WIDTH  = SC_WIDTH,
    parameter int unsigned WINDOW = SC_WINDOW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] prob,
    input  logic [WIDTH-1:0] rnd,
    output logic             sbit,
    output logic             sbit_valid,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] LAST_SAMPLE = WIDTH'(WINDOW - 1);

    sc_state_t        state;
    sc_state_t        state_next;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] smp_cnt;
    logic             cmp_bit;
    logic             load;
    logic             sample;
    logic             last;

    sc_compare #(
        .WIDTH(WIDTH)
    ) u_compare (
        .a  (rnd),
        .b  (op),
        .lt (cmp_bit)
    );

    assign acc_sum = acc + {{(WIDTH-1){1'b0}}, cmp_bit};
    assign busy    = (state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        sample     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (enable) begin
                    sample = 1'b1;
                    if (smp_cnt == LAST_SAMPLE) begin
                        last       = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // done is registered off the DONE state so it lands one edge after the
    // final sample, by which time count already holds the window total.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op         <= '0;
            acc        <= '0;
            smp_cnt    <= '0;
            sbit       <= 1'b0;
            sbit_valid <= 1'b0;
            count      <= '0;
            done       <= 1'b0;
        end else begin
            sbit_valid <= sample;
            done       <= (state == DONE);
            if (load) begin
                op      <= prob;
                acc     <= '0;
                smp_cnt <= '0;
            end
            if (sample) begin
                sbit    <= cmp_bit;
                acc     <= acc_sum;
                smp_cnt <= smp_cnt + 1'b1;
            end
            if (last) begin
                count <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder: LFSR-driven stream, window-level reference
// model, directed scenarios followed by randomized windows.
module tb_sc_stream_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       start;
    logic [7:0] prob;
    logic [7:0] rnd;
    logic       sbit;
    logic       sbit_valid;
    logic [7:0] count;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: 0 idle, 1 sampling, 2 finishing
    int   m_phase = 0;
    int   m_left  = 0;
    int   m_op    = 0;
    int   m_acc   = 0;
    int   m_count = 0;
    logic exp_sbit  = 1'b0;
    logic exp_valid = 1'b0;
    logic exp_done  = 1'b0;

    always #5 clk = ~clk;

    sc_stream_decoder #(
        .WIDTH  (8),
        .WINDOW (255)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .prob       (prob),
        .rnd        (rnd),
        .sbit       (sbit),
        .sbit_valid (sbit_valid),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    // upstream SNG: maximal 8-bit LFSR (x^8+x^6+x^5+x^4+1), seed 8'h21
    always @(posedge clk or negedge reset) begin
        if (!reset) rnd <= 8'h21;
        else if (enable) rnd <= {rnd[6:0], rnd[7] ^ rnd[5] ^ rnd[4] ^ rnd[3]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_phase = 0; m_left = 0; m_op = 0; m_acc = 0; m_count = 0;
                exp_sbit = 1'b0; exp_valid = 1'b0; exp_done = 1'b0;
            end else begin
                exp_valid = 1'b0;
                exp_done  = 1'b0;
                case (m_phase)
                    0: if (start) begin
                        m_op = int'(prob); m_acc = 0; m_left = 255; m_phase = 1;
                    end
                    1: if (enable) begin
                        exp_sbit  = (int'(rnd) < m_op);
                        exp_valid = 1'b1;
                        m_acc     = m_acc + int'(exp_sbit);
                        m_left    = m_left - 1;
                        if (m_left == 0) begin
                            m_count = m_acc;
                            m_phase = 2;
                        end
                    end
                    default: begin
                        exp_done = 1'b1;
                        m_phase  = 0;
                    end
                endcase
            end
        end
    end

    initial begin : checker_loop
        forever begin
            @(negedge clk);
            check("sbit_valid", sbit_valid, exp_valid);
            check("sbit", sbit, exp_sbit);
            check("done", done, exp_done);
            check("busy", busy, m_phase == 1);
            check("count", count, m_count[7:0]);
        end
    end

    // mode 0: enable high, 1: enable 1/0 alternating, 2: random enable
    task automatic run_window(input logic [7:0] p, input int mode, input logic [7:0] mid_p,
                              input int mid_at, input logic [7:0] prev_cnt,
                              output int edges, output int nv);
        edges = 0;
        nv    = 0;
        @(negedge clk);
        start  = 1'b1;
        prob   = p;
        enable = 1'b1;
        @(posedge clk);
        #1 check("count_kept", count, prev_cnt);
        while (edges < 2000) begin
            @(negedge clk);
            start = (edges + 1 == mid_at);
            if (start) prob = mid_p;
            case (mode)
                0:       enable = 1'b1;
                1:       enable = (edges % 2 == 0);
                default: enable = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk);
            #1;
            edges++;
            if (sbit_valid) nv++;
            if (done) break;
        end
        if (!done) check("done_timeout", 0, 1);
        start  = 1'b0;
        enable = 1'b1;
    endtask

    initial begin : stimulus
        int edges;
        int nv;
        logic [7:0] p;
        logic [7:0] last_cnt;
        int mid;

        reset  = 1'b0;
        start  = 1'b0;
        enable = 1'b1;
        prob   = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_sbit", sbit, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        run_window(8'h80, 0, 8'h00, -1, 8'd0, edges, nv);
        check("lat_80", edges, 256);
        check("cnt_80", count, 127);
        check("pulses_80", nv, 255);
        check("busy_after", busy, 0);

        run_window(8'h00, 0, 8'h00, -1, 8'd127, edges, nv);
        check("cnt_00", count, 0);
        run_window(8'hFF, 0, 8'h00, -1, 8'd0, edges, nv);
        check("cnt_ff", count, 254);

        run_window(8'h80, 1, 8'h00, -1, 8'd254, edges, nv);
        check("lat_toggle", edges, 510);
        check("cnt_toggle", count, 127);

        run_window(8'h80, 0, 8'h10, 50, 8'd127, edges, nv);
        check("lat_midstart", edges, 256);
        check("cnt_midstart", count, 127);

        run_window(8'h80, 0, 8'h00, -1, 8'd127, edges, nv);
        check("cnt_b2b_a", count, 127);
        run_window(8'h20, 0, 8'h00, -1, 8'd127, edges, nv);
        check("cnt_b2b_b", count, 31);

        @(negedge clk);
        start = 1'b1;
        prob  = 8'h80;
        @(posedge clk);
        repeat (100) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
        end
        #2 reset = 1'b0;
        #1;
        check("arst_sbit", sbit, 0);
        check("arst_valid", sbit_valid, 0);
        check("arst_count", count, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        run_window(8'h40, 0, 8'h00, -1, 8'd0, edges, nv);
        check("lat_40", edges, 256);
        check("cnt_40", count, 63);

        last_cnt = 8'd63;
        for (int i = 0; i < 6; i++) begin
            p   = 8'($urandom_range(0, 255));
            mid = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 200)) : -1;
            run_window(p, 2, 8'($urandom), mid, last_cnt, edges, nv);
            last_cnt = (p == 8'd0) ? 8'd0 : p - 8'd1;
            check("cnt_rand", count, last_cnt);
            check("pulses_rand", nv, 255);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sc_stream_decoder.md
SC_STREAM_DECODER -- requirements
Module: sc_stream_decoder

Interface
REQ-001 Parameter WIDTH, default 8: operand and random-word width.
REQ-002 Parameter WINDOW, default 255: samples per conversion window, equal to the 8-bit LFSR period.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port enable, input, 1: sample qualifier, tied to the same enable that drives the upstream SNG.
REQ-006 Port start, input, 1: single-cycle request to begin a conversion window.
REQ-007 Port prob, input, WIDTH: binary operand (probability numerator), captured on an accepted start.
REQ-008 Port rnd, input, WIDTH: random word from the upstream SNG data output.
REQ-009 Port sbit, output, 1: registered stochastic bit.
REQ-010 Port sbit_valid, output, 1: high for each cycle that sbit carries a fresh sample.
REQ-011 Port count, output, WIDTH: number of ones in the last completed window.
REQ-012 Port busy, output, 1: high while a window is in progress.
REQ-013 Port done, output, 1: one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; reset state IDLE.
REQ-015 IDLE with start=1 SHALL latch prob into op, clear the accumulator and sample counter, and enter RUN on the next edge.
REQ-016 RUN with enable=1 SHALL compute bit = (rnd < op) as an unsigned compare, register it to sbit with sbit_valid=1, add bit to the accumulator, and increment the sample counter.
REQ-017 RUN with enable=0 SHALL hold the accumulator, sample counter and sbit, and SHALL drive sbit_valid=0.
REQ-018 On the enabled sample at which the sample counter equals WINDOW-1, the block SHALL load count with the accumulator plus the bit, enter DONE, and pulse done high for exactly one cycle.
REQ-019 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-020 Latency with enable held high: done SHALL be asserted in the cycle WINDOW+1 edges after the edge that accepted start.
REQ-021 busy SHALL equal (state==RUN).
REQ-022 start SHALL be ignored in RUN and in DONE; no restart and no op reload may occur.
REQ-023 count SHALL hold its value from done until the next window completes; a new start SHALL NOT clear count.
REQ-024 Accumulator width SHALL be WIDTH bits and the accumulator SHALL never wrap, because the maximum ones count is WINDOW-1 when rnd is never zero and WINDOW when it is.
REQ-025 With op=0 the stream SHALL be all zeros; with op=2^WIDTH-1 only rnd=2^WIDTH-1 yields zero.

Reset
REQ-026 Asserting reset low at any time, including mid-window, SHALL immediately force state=IDLE, op=0, accumulator=0, sample counter=0, sbit=0, sbit_valid=0, count=0, busy=0 and done=0.
REQ-027 After reset is released, the block SHALL accept start on the first rising edge at which start is high.

Structure
REQ-028 Shared package sc_pkg SHALL hold the WIDTH and WINDOW defaults and the state encoding constants (IDLE, RUN, DONE).
REQ-029 The comparator SHALL be a separate combinational sub-module sc_compare (inputs a and b, output lt), reused by future stochastic stages.
REQ-030 The accumulator, sample counter, FSM and output registers SHALL reside in sc_stream_decoder.

Verification
REQ-031 SNG seeded with 8'h21 and enable high, prob=8'h80, one start -> done after 256 edges, count=127, 255 sbit_valid pulses.
REQ-032 prob=8'h00 -> sbit stays 0 and count=0; prob=8'hFF -> count=254.
REQ-033 prob=8'h80 with enable toggled 1/0 every cycle -> done after 510 edges, count=127, sbit held steady while enable=0.
REQ-034 start re-pulsed mid-RUN with prob=8'h10 -> ignored, window completes with count=127 (op stays 8'h80).
REQ-035 reset pulsed low at sample 100 -> all outputs read 0 asynchronously; a new start with prob=8'h40 -> count=63.
REQ-036 Back-to-back windows (start in the cycle after done) with prob=8'h80 and then 8'h20 -> count reads 127 then 31, and count does not change at the second start.
